ram_bist_ctrl: RTL and testbench

- Built-in self-test initiator for the team's single-port synchronous RAM (256x8 default). Drives the RAM's address, write-data and write-enable inputs and checks its registered read data.
- Runs a March C- sequence over every address and reports pass/fail.
- Sits between the RAM and the system control/status logic. The mission-mode mux onto the RAM port is outside this block.

---
 rtl/ram_bist_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl - March C- built-in self-test initiator for a single-port
// synchronous RAM (registered read data, one-cycle read latency).
//
// March sequence (N = 2**ADDR_W, "0" = all zeros, "1" = all ones):
//   E0 asc  w0 | E1 asc  r0,w1 | E2 asc  r1,w0
//   E3 desc r0,w1 | E4 desc r1,w0 | E5 desc r0
// E0 takes one cycle per address; E1..E5 take two cycles per address
// (RD issues the read, CMP checks the returned data and issues the write).
// A fault-free run keeps busy high for exactly 11*N cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a test (sampled only in IDLE)
//   busy       high while the march sequence runs
//   done       one-cycle pulse at the end of a test
//   pass       result of the last completed test, held until next start
//   fail_addr  address of the first miscompare
//   fail_data  data read at the first miscompare
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_we     RAM write enable (low = read cycle)
//   mem_rdata  RAM read data, valid the cycle after a read
//   err_count  (RAM_BIST_ERR_CNT_EN only) saturating miscompare count
//
// Build option RAM_BIST_ERR_CNT_EN: when defined, adds err_count and the
// test no longer stops at the first miscompare; the write in a failing CMP
// cycle still happens so the march runs to completion.

module ram_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef RAM_BIST_ERR_CNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_RD   = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] BG_ZERO   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] BG_ONE    = {DATA_W{1'b1}};

`ifdef RAM_BIST_ERR_CNT_EN
    localparam logic STOP_ON_FAIL = 1'b0;
`else
    localparam logic STOP_ON_FAIL = 1'b1;
`endif

    state_t            state_r, state_nx;
    logic [ADDR_W-1:0] addr_r, addr_nx;
    logic [2:0]        elem_r, elem_nx;   // march element index 0..5
    logic              busy_r, done_r, pass_r, fail_seen_r;
    logic [ADDR_W-1:0] fail_addr_r;
    logic [DATA_W-1:0] fail_data_r;

    logic              desc_s, last_addr_s, miscmp_s;
    logic [DATA_W-1:0] exp_bg_s, new_bg_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Element decode: direction, expected/new background, boundary and compare
    always_comb begin
        desc_s      = (elem_r >= 3'd3);
        exp_bg_s    = ((elem_r == 3'd2) || (elem_r == 3'd4)) ? BG_ONE : BG_ZERO;
        new_bg_s    = ((elem_r == 3'd1) || (elem_r == 3'd3)) ? BG_ONE : BG_ZERO;
        last_addr_s = desc_s ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);
        miscmp_s    = (state_r == S_CMP) && (mem_rdata != exp_bg_s);
    end

    // Next-state, next-address and next-element logic
    always_comb begin
        state_nx = state_r;
        addr_nx  = addr_r;
        elem_nx  = elem_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_M0;
                    addr_nx  = ADDR_ZERO;
                    elem_nx  = 3'd0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_M0: begin
                if (addr_r == ADDR_MAX) begin
                    state_nx = S_RD;
                    addr_nx  = ADDR_ZERO;
                    elem_nx  = 3'd1;
                end else begin
                    addr_nx  = addr_r + ADDR_ONE;
                end
            end
            S_RD: begin
                state_nx = S_CMP;
            end
            S_CMP: begin
                if (miscmp_s && STOP_ON_FAIL) begin
                    // Abort at the first failure; address stays on the failing cell
                    state_nx = S_DONE;
                end else if (last_addr_s) begin
                    if (elem_r == 3'd5) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RD;
                        elem_nx  = elem_r + 3'd1;
                        // E3..E5 are descending and start from the top address
                        addr_nx  = (elem_r >= 3'd2) ? ADDR_MAX : ADDR_ZERO;
                    end
                end else begin
                    state_nx = S_RD;
                    addr_nx  = desc_s ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                addr_nx  = ADDR_ZERO;
                elem_nx  = 3'd0;
            end
            default: begin
                state_nx = S_IDLE;
                addr_nx  = ADDR_ZERO;
                elem_nx  = 3'd0;
            end
        endcase
    end

    // State, address and element registers plus registered busy/done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            addr_r  <= ADDR_ZERO;
            elem_r  <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            addr_r  <= addr_nx;
            elem_r  <= elem_nx;
            busy_r  <= (state_nx == S_M0) || (state_nx == S_RD) || (state_nx == S_CMP);
            done_r  <= (state_nx == S_DONE);
        end
    end

    // RAM port drive; the CMP write is gated by the same-cycle compare result
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wdata_s = BG_ZERO;
        case (state_r)
            S_M0: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = BG_ZERO;
            end
            S_CMP: begin
                mem_we_s    = (elem_r != 3'd5) && !(miscmp_s && STOP_ON_FAIL);
                mem_wdata_s = new_bg_s;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_wdata_s = BG_ZERO;
            end
        endcase
    end

    // Result capture: first-failure address/data and the pass flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_r      <= 1'b0;
            fail_seen_r <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
            fail_data_r <= BG_ZERO;
        end else if ((state_r == S_IDLE) && start) begin
            pass_r      <= 1'b0;
            fail_seen_r <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
            fail_data_r <= BG_ZERO;
        end else begin
            if (miscmp_s && !fail_seen_r) begin
                fail_seen_r <= 1'b1;
                fail_addr_r <= addr_r;
                fail_data_r <= mem_rdata;
            end
            if ((state_r == S_CMP) && (state_nx == S_DONE)) begin
                pass_r <= !(fail_seen_r || miscmp_s);
            end
        end
    end

`ifdef RAM_BIST_ERR_CNT_EN
    logic [15:0] err_cnt_r;

    // Saturating miscompare counter, cleared when a test starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= 16'd0;
        end else if ((state_r == S_IDLE) && start) begin
            err_cnt_r <= 16'd0;
        end else if (miscmp_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign err_count = err_cnt_r;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_addr = fail_addr_r;
    assign fail_data = fail_data_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = mem_wdata_s;
    assign mem_we    = mem_we_s;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural 256x8 RAM that can
// inject stuck-at and address-aliasing faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass, mem_we;
    logic [7:0] fail_addr, fail_data, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
`ifdef RAM_BIST_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int we_viol     = 0;
    bit we_chk_en   = 1'b0;
    int fault_mode  = 0;   // 0 none, 1 bit3 sa0 @5A, 2 alias 10->90, 3 bit0 sa0 @01,FE
    int cnt;

    logic [7:0] ram [256];

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
`ifdef RAM_BIST_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    function automatic logic [7:0] stuck_mask(input logic [7:0] a);
        if (fault_mode == 1 && a == 8'h5A) return 8'h08;
        if (fault_mode == 3 && (a == 8'h01 || a == 8'hFE)) return 8'h01;
        return 8'h00;
    endfunction

    // Behavioural RAM with registered read data
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata & ~stuck_mask(mem_addr);
            if (fault_mode == 2 && mem_addr == 8'h10) ram[8'h90] <= mem_wdata;
        end else begin
            mem_rdata <= ram[mem_addr];
        end
    end

    // Write enable must never be asserted outside busy
    always @(negedge clk) begin
        if (we_chk_en && mem_we && !busy) we_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count busy cycles from the current sample until done (bounded)
    task automatic run_to_done(input int start_cnt, output int n);
        n = start_cnt;
        for (int i = 0; i < 4000; i++) begin
            if (done) break;
            if (busy) n++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_pass",      pass,      1'b0);
        check("rst_fail_addr", fail_addr, 8'h00);
        check("rst_fail_data", fail_data, 8'h00);
        check("rst_mem_addr",  mem_addr,  8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_mem_we",    mem_we,    1'b0);
        rst_n = 1'b1;
        we_chk_en = 1'b1;
        tick();

        // Fault-free run: 11*256 busy cycles, then a one-cycle done
        fault_mode = 0;
        pulse_start();
        check("ff_busy_first", busy, 1'b1);
        check("ff_we_first",   mem_we, 1'b1);
        run_to_done(0, cnt);
        check("ff_busy_cycles", cnt, 32'd2816);
        check("ff_done",      done, 1'b1);
        check("ff_pass",      pass, 1'b1);
        check("ff_fail_addr", fail_addr, 8'h00);
        check("ff_fail_data", fail_data, 8'h00);
        tick();
        check("ff_done_pulse", done, 1'b0);
        check("ff_pass_held",  pass, 1'b1);

`ifndef RAM_BIST_ERR_CNT_EN
        // Bit 3 stuck-at-0 at 5A: E1 stores F7, E2 read of 1s fails there.
        // busy = 256 (E0) + 512 (E1) + 2*91 (E2 up to 5A) = 950
        fault_mode = 1;
        pulse_start();
        run_to_done(0, cnt);
        check("sa_busy_cycles", cnt, 32'd950);
        check("sa_done",      done, 1'b1);
        check("sa_pass",      pass, 1'b0);
        check("sa_fail_addr", fail_addr, 8'h5A);
        check("sa_fail_data", fail_data, 8'hF7);
        tick();

        // Alias 10->90: E1 writes FF at 10, which also lands in 90, so the
        // E1 read of 0 at 90 returns FF. busy = 256 + 2*145 = 546
        fault_mode = 2;
        pulse_start();
        run_to_done(0, cnt);
        check("al_busy_cycles", cnt, 32'd546);
        check("al_pass",      pass, 1'b0);
        check("al_fail_addr", fail_addr, 8'h90);
        check("al_fail_data", fail_data, 8'hFF);
        tick();
`else
        // Bit 0 stuck-at-0 at 01 and FE: each faulty cell misreads on the
        // two reads of background 1 (E2 and E4) -> 4 miscompares in total.
        // First failure is E2 at 01 reading FE.
        fault_mode = 3;
        pulse_start();
        run_to_done(0, cnt);
        check("ec_busy_cycles", cnt, 32'd2816);
        check("ec_pass",      pass, 1'b0);
        check("ec_fail_addr", fail_addr, 8'h01);
        check("ec_fail_data", fail_data, 8'hFE);
        check("ec_err_count", err_count, 16'd4);
        tick();
`endif

        // Reset at busy cycle 1000 aborts the test
        fault_mode = 0;
        pulse_start();
        for (int i = 0; i < 999; i++) tick();
        check("mr_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy",      busy,      1'b0);
        check("mr_done",      done,      1'b0);
        check("mr_pass",      pass,      1'b0);
        check("mr_mem_we",    mem_we,    1'b0);
        check("mr_mem_addr",  mem_addr,  8'h00);
        check("mr_mem_wdata", mem_wdata, 8'h00);
        tick();
        tick();
        check("mr_idle", {busy, done}, 2'b00);
        pulse_start();
        run_to_done(0, cnt);
        check("mr_rerun_cycles", cnt, 32'd2816);
        check("mr_rerun_pass",   pass, 1'b1);
        tick();

        // start asserted at busy cycle 50 and held through DONE
        pulse_start();
        for (int i = 0; i < 49; i++) tick();
        start = 1'b1;
        run_to_done(49, cnt);
        check("sh_first_cycles", cnt, 32'd2816);
        check("sh_first_pass",   pass, 1'b1);
        tick();
        check("sh_idle", {busy, done}, 2'b00);
        tick();
        check("sh_second_busy", busy, 1'b1);
        start = 1'b0;
        run_to_done(0, cnt);
        check("sh_second_cycles", cnt, 32'd2816);
        check("sh_second_pass",   pass, 1'b1);
        tick();

        check("we_outside_busy", we_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
